// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// State encoding, default parameter values and a small helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_OUT       = 3;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_STAGE_GAP     = 4;
    localparam int DEF_FILTER_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchronizer: STAGES flops, async set, D = 0.
// Ports: clk, rst (async set, active-high), rst_sync (last stage).
module reset_sync
    import reset_seq_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: async assert, sync ordered release.
// Ports: clk, R, ext_rst_req, sw_rst_req, rst_out[NUM_OUT], done.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT       = DEF_NUM_OUT,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic               clk,
    input  logic               R,
    input  logic               ext_rst_req,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               done
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IW = $clog2(NUM_OUT + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_END   = IW'(NUM_OUT);
    localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [FW-1:0] FLT_FULL  = FW'(FILTER_CYCLES);

    seq_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     flt_q, flt_d;
    logic              armed_q, armed_d;
    logic [NUM_OUT-1:0] rst_out_d;
    logic              rst_sync;
    logic              fire;
    logic              restart;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (R),
        .rst_sync(rst_sync)
    );

    // Glitch filter: one fire per high run, re-armed by a low sample.
    always_comb begin
        flt_d   = flt_q;
        armed_d = armed_q;
        fire    = 1'b0;
        if (ext_rst_req) begin
            if (flt_q != FLT_FULL) begin
                flt_d = flt_q + FW'(1);
            end
            if (armed_q && (flt_q == FLT_LAST)) begin
                fire    = 1'b1;
                armed_d = 1'b0;
            end
        end else begin
            flt_d   = '0;
            armed_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out;
        restart   = (sw_rst_req && (state_q == RUN))
                  || (fire && (state_q != ASSERT));
        if (restart) begin
            state_d   = HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    if (!rst_sync) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        idx_d        = IW'(1);
                        cnt_d        = '0;
                        state_d      = RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    // idx == NUM_OUT means the last bit cleared last edge.
                    if (idx_q == IDX_END) begin
                        state_d = RUN;
                    end else if (cnt_q == GAP_LAST) begin
                        rst_out_d = rst_out & ~(NUM_OUT'(1) << idx_q);
                        idx_d     = idx_q + IW'(1);
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            flt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            flt_q   <= flt_d;
            armed_q <= armed_d;
        end
    end

    // Output flops: set straight from R, nothing after the Q pins.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            rst_out <= '1;
        end else begin
            rst_out <= rst_out_d;
        end
    end

    assign done = (state_q == RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: edge-indexed vector table
// plus hand sequences for the R glitch and a minimal parameter set.
module tb_reset_sequencer;

    typedef struct {
        int         edge_n;
        logic       sw;
        logic       ext;
        logic [2:0] exp_out;
        logic       exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       R;
    logic       ext;
    logic       sw;
    logic [2:0] rst_out;
    logic       done;
    logic       r1;
    logic       tie0 = 1'b0;
    logic [0:0] out1;
    logic       done1;

    int   cyc;
    int   tests;
    int   fails;
    vec_t vecs[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT(3), .SYNC_STAGES(2), .HOLD_CYCLES(16),
        .STAGE_GAP(4), .FILTER_CYCLES(4)
    ) dut (
        .clk(clk), .R(R), .ext_rst_req(ext), .sw_rst_req(sw),
        .rst_out(rst_out), .done(done)
    );

    reset_sequencer #(
        .NUM_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(1),
        .STAGE_GAP(1), .FILTER_CYCLES(4)
    ) dut1 (
        .clk(clk), .R(r1), .ext_rst_req(tie0), .sw_rst_req(tie0),
        .rst_out(out1), .done(done1)
    );

    task automatic add(input int e, input logic s, input logic x,
                       input logic [2:0] o, input logic d);
        vec_t v;
        v.edge_n   = e;
        v.sw       = s;
        v.ext      = x;
        v.exp_out  = o;
        v.exp_done = d;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(input string nm,
                         input logic [2:0] go, input logic gd,
                         input logic [2:0] eo, input logic ed);
        tests++;
        if (go !== eo || gd !== ed) begin
            fails++;
            $display("FAIL %s: rst_out=%b done=%b, expected rst_out=%b done=%b",
                     nm, go, gd, eo, ed);
        end
    endtask

    task automatic run_vec(input int i);
        while (cyc < vecs[i].edge_n - 1) tick();
        sw  = vecs[i].sw;
        ext = vecs[i].ext;
        tick();
        sw = 1'b0;
        check($sformatf("vec%0d@edge%0d", i, vecs[i].edge_n),
              rst_out, done, vecs[i].exp_out, vecs[i].exp_done);
    endtask

    initial begin
        logic s_out[5];
        logic s_done[5];
        s_out  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // power-up release
        add(  2, 0, 0, 3'b111, 0);
        add( 18, 0, 0, 3'b111, 0);
        add( 19, 0, 0, 3'b110, 0);
        add( 22, 0, 0, 3'b110, 0);
        add( 23, 0, 0, 3'b100, 0);
        add( 26, 0, 0, 3'b100, 0);
        add( 27, 0, 0, 3'b000, 0);
        add( 28, 0, 0, 3'b000, 1);
        // software restart, second pulse in HOLD ignored
        add( 40, 1, 0, 3'b111, 0);
        add( 45, 1, 0, 3'b111, 0);
        add( 55, 0, 0, 3'b111, 0);
        add( 56, 0, 0, 3'b110, 0);
        add( 60, 0, 0, 3'b100, 0);
        add( 64, 0, 0, 3'b000, 0);
        add( 65, 0, 0, 3'b000, 1);
        // 3-cycle ext pulse: filtered out
        add( 70, 0, 1, 3'b000, 1);
        add( 71, 0, 1, 3'b000, 1);
        add( 72, 0, 1, 3'b000, 1);
        add( 73, 0, 0, 3'b000, 1);
        add( 76, 0, 0, 3'b000, 1);
        // ext held 20 cycles from edge 80: one restart at 83
        add( 80, 0, 1, 3'b000, 1);
        add( 82, 0, 1, 3'b000, 1);
        add( 83, 0, 1, 3'b111, 0);
        add( 98, 0, 1, 3'b111, 0);
        add( 99, 0, 1, 3'b110, 0);
        add(100, 0, 0, 3'b110, 0);
        add(103, 0, 0, 3'b100, 0);
        add(107, 0, 0, 3'b000, 0);
        add(108, 0, 0, 3'b000, 1);
        // sw and filtered request together at edge 123
        add(120, 0, 1, 3'b000, 1);
        add(122, 0, 1, 3'b000, 1);
        add(123, 1, 1, 3'b111, 0);
        add(124, 0, 0, 3'b111, 0);
        add(138, 0, 0, 3'b111, 0);
        add(139, 0, 0, 3'b110, 0);
        add(143, 0, 0, 3'b100, 0);
        add(147, 0, 0, 3'b000, 0);
        add(148, 0, 0, 3'b000, 1);
        // get into RELEASE for the R glitch
        add(160, 1, 0, 3'b111, 0);
        add(176, 0, 0, 3'b110, 0);
        add(178, 0, 0, 3'b110, 0);

        tests = 0;
        fails = 0;
        cyc   = 0;
        R     = 1'b0;
        r1    = 1'b0;
        sw    = 1'b0;
        ext   = 1'b0;
        #1;
        R  = 1'b1;
        r1 = 1'b1;
        #1;
        check("reset_state", rst_out, done, 3'b111, 1'b0);
        check("reset_state_p1", {2'b00, out1}, done1, 3'b001, 1'b0);

        tick();
        tick();
        R   = 1'b0;
        cyc = 0;
        foreach (vecs[i]) run_vec(i);

        // 3 ns R glitch mid-RELEASE
        R = 1'b1;
        #1;
        check("glitch_async", rst_out, done, 3'b111, 1'b0);
        #2;
        R   = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) run_vec(i);

        // NUM_OUT=1, HOLD=1, GAP=1
        r1 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("p1@edge%0d", e), {2'b00, out1}, done1,
                  {2'b00, s_out[e-1]}, s_done[e-1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock reset controller that generates the staged, active-high reset lines consumed by the design's sequential blocks. It takes the raw asynchronous reset `R` and produces `NUM_OUT` registered reset outputs, each a single-bit flop output. Each output asserts asynchronously and deasserts synchronously, in a fixed order. Downstream flops test each output directly as a simple `posedge` asynchronous-reset condition. The block also accepts a filtered external reset request and a software restart pulse.

## Interface
- `NUM_OUT`, 3: number of staged reset outputs, range 1..16.
- `SYNC_STAGES`, 2: depth of the `R` deassertion synchronizer, ≥2.
- `HOLD_CYCLES`, 16: cycles all outputs stay asserted after the synchronized release, ≥1.
- `STAGE_GAP`, 4: cycles between consecutive output releases, ≥1.
- `FILTER_CYCLES`, 4: consecutive high cycles required on `ext_rst_req`, ≥1.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `R`  in  1  reset; **asynchronous, active-high** (already decided); may be fully asynchronous to `clk`.
- `ext_rst_req`  in  1  external reset request, synchronous to `clk`, glitch-filtered internally.
- `sw_rst_req`  in  1  software restart, single-cycle pulse, synchronous.
- `rst_out`  out  NUM_OUT  staged resets, active-high; bit 0 releases first.
- `done`  out  1  high when every `rst_out` bit is released (state RUN).

## Operation
- **Reset.** `R` high asynchronously forces the following, with no clock needed:
  - `rst_out` = all ones, `done` = 0;
  - synchronizer chain = all ones;
  - state = ASSERT, counters = 0;
  - filter counter = 0, filter-armed = 1.
- **Synchronizer.** The chain is `SYNC_STAGES` flops, set by `R`, with D = 0. Its last stage is `rst_sync`.
- **FSM (2-bit).**
  - ASSERT: wait for `rst_sync` = 0, then go to HOLD with counter = 0.
  - HOLD: count up. At the edge where counter reaches `HOLD_CYCLES`, clear `rst_out[0]`, set idx = 1, reset counter, and go to RELEASE. If `NUM_OUT` = 1, go to RUN via RELEASE as well.
  - RELEASE: count `STAGE_GAP` cycles, then clear `rst_out[idx]` and increment idx. One edge after the last bit clears, go to RUN.
  - RUN: `done` = 1.
- **Restart.** A restart sets `rst_out` to all ones and `done` = 0, takes the FSM to HOLD, and sets counter = 0, all on the same edge as the trigger.
  - Trigger: `sw_rst_req` sampled high in RUN. The pulse is ignored in every other state.
  - Trigger: the filtered external request, accepted in HOLD, RELEASE and RUN. It is ignored in ASSERT.
- **Filter.**
  - The counter increments while `ext_rst_req` = 1 and clears when it is 0. It saturates at `FILTER_CYCLES`.
  - The request fires on the edge where the counter reaches `FILTER_CYCLES` while armed, then disarms.
  - It re-arms only after `ext_rst_req` is sampled 0. A held-high input therefore causes exactly one restart.
- **Simultaneous triggers.** A software and filtered request on the same edge cause one restart. `R` overrides everything.
- **Counter width.** $clog2(max(HOLD_CYCLES, STAGE_GAP)+1) bits; no wrap is reachable.

## Timing
- Edge 1 is the first rising edge with `R` low; edge numbers below count from it.
- `rst_sync` falls at edge `SYNC_STAGES`.
- ASSERT→HOLD happens at edge `SYNC_STAGES+1`.
- `rst_out[i]` falls at edge `SYNC_STAGES+1+HOLD_CYCLES+i*STAGE_GAP`. With defaults: 19, 23, 27.
- `done` rises one edge after the last release. With defaults: edge 28.
- For a restart triggered at edge n: `rst_out` goes all ones at n, and `rst_out[0]` falls at n+`HOLD_CYCLES`.
- Filtered request: with `ext_rst_req` high from edge m, the restart occurs at edge m+`FILTER_CYCLES`-1.
- `R` asserted mid-sequence: outputs are set immediately, asynchronously, and the timing above restarts from the next release of `R`.
- A glitch on `R` shorter than one cycle still produces a full sequence.

## Structure
- **Package `reset_seq_pkg`:**
  - state encoding: ASSERT = 0, HOLD = 1, RELEASE = 2, RUN = 3;
  - default parameter constants.
- **Sub-module `reset_sync`:** N-flop chain, asynchronously set, synchronously cleared. It is instantiated once for `R`.
- **Remaining logic:** FSM, shared hold/gap counter, release index and filter in `reset_sequencer`.
- **Output flops:** each `rst_out` bit is its own flop, set directly by `R`, with no combinational logic on the output.

## Test plan
- Power-up, defaults: drop `R` before edge 1 → `rst_out` = 3'b110 at edge 19, 3'b100 at edge 23, 3'b000 at edge 27; `done` = 1 at edge 28.
- `R` pulsed high for 3 ns mid-RELEASE, at edge 21 → `rst_out` = 3'b111 immediately and `done` = 0; the release sequence repeats with the same offsets from the new deassertion.
- `sw_rst_req` pulse at edge 40 (RUN) → `rst_out` = 3'b111 at edge 40, `rst_out[0]` falls at edge 56. A second pulse at edge 45 (HOLD) is ignored.
- Filter:
  - `ext_rst_req` high for 3 cycles, then low → no restart.
  - High from edge 60 for 20 cycles → one restart at edge 63, and no second restart.
- `sw_rst_req` and the filtered request fire on the same edge → a single restart, with the timing identical to a single trigger.
- Parameter sweep: `NUM_OUT` = 1, `HOLD_CYCLES` = 1, `STAGE_GAP` = 1 → `rst_out` falls at edge 4 and `done` rises at edge 5.
